// File: rtl/render_pkg.sv
// Shared constants for the render compositor: colour defaults and the blanking value.
package render_pkg;
   localparam int          COLOR_W_DEF        = 12;
   localparam logic [11:0] DEFAULT_BG         = 12'h49C;
   localparam logic [11:0] DEFAULT_LINE_COLOR = 12'hF00;
   localparam logic [11:0] BLANK_COLOR        = 12'h000;
endpackage

// File: rtl/msb_priority_index.sv
// Highest-set-bit encoder: idx of the top asserted bit, none when the vector is zero.
module msb_priority_index #(
   parameter int N  = 10,
   parameter int IW = $clog2(N + 1)
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          none
);
   always_comb begin
      idx  = '0;
      none = 1'b1;
      // later iterations overwrite earlier ones, so the highest set bit wins
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx  = IW'(i);
            none = 1'b0;
         end
      end
   end
endmodule

// File: rtl/render_compositor.sv
// Two-stage pixel compositor: priority-encode hit channels, then look up a
// resettable flop palette with frame-rate blinking toward the background colour.
module render_compositor
   import render_pkg::*;
#(
   parameter int N_CH      = 10,
   parameter int COLOR_W   = COLOR_W_DEF,
   parameter int BLINK_DIV = 30,
   parameter int IDX_W     = $clog2(N_CH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hit_valid,
   input  logic [N_CH-1:0]    hit,
   input  logic               frame_start,
   input  logic               pal_we,
   input  logic [IDX_W-1:0]   pal_addr,
   input  logic [COLOR_W-1:0] pal_wdata,
   input  logic [N_CH-1:0]    blink_mask,
   output logic               out_valid,
   output logic [COLOR_W-1:0] vga_data
);
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [IDX_W-1:0]   enc_idx;
   logic               enc_none;
   logic [IDX_W-1:0]   idx1_d, idx1_q;
   logic               v1_d, v1_q;
   logic               blink1_d, blink1_q;
   logic               out_valid_d, out_valid_q;
   logic [COLOR_W-1:0] vga_d, vga_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic               phase_d, phase_q;
   logic [COLOR_W-1:0] pal_d [0:N_CH];
   logic [COLOR_W-1:0] pal_q [0:N_CH];
   logic               sel_mask;

   msb_priority_index #(.N(N_CH), .IW(IDX_W)) u_enc (
      .vec  (hit),
      .idx  (enc_idx),
      .none (enc_none)
   );

   always_comb begin
      sel_mask = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (enc_idx == IDX_W'(i)) sel_mask = blink_mask[i];
      idx1_d   = enc_none ? IDX_W'(N_CH) : enc_idx;
      v1_d     = hit_valid;
      // phase is captured with the pixel, so a coincident frame_start toggle lands on later pixels
      blink1_d = !enc_none && sel_mask && phase_q;
   end

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (frame_start) begin
         if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i <= N_CH; i++)
         pal_d[i] = (pal_we && pal_addr == IDX_W'(i)) ? pal_wdata : pal_q[i];
   end

   always_comb begin
      out_valid_d = v1_q;
      vga_d       = COLOR_W'(BLANK_COLOR);
      if (v1_q) vga_d = blink1_q ? pal_q[N_CH] : pal_q[idx1_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx1_q      <= IDX_W'(N_CH);
         v1_q        <= 1'b0;
         blink1_q    <= 1'b0;
         out_valid_q <= 1'b0;
         vga_q       <= COLOR_W'(BLANK_COLOR);
         cnt_q       <= '0;
         phase_q     <= 1'b0;
         for (int i = 0; i < N_CH; i++) pal_q[i] <= COLOR_W'(DEFAULT_LINE_COLOR);
         pal_q[N_CH] <= COLOR_W'(DEFAULT_BG);
      end else begin
         idx1_q      <= idx1_d;
         v1_q        <= v1_d;
         blink1_q    <= blink1_d;
         out_valid_q <= out_valid_d;
         vga_q       <= vga_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         for (int i = 0; i <= N_CH; i++) pal_q[i] <= pal_d[i];
      end
   end

   assign out_valid = out_valid_q;
   assign vga_data  = vga_q;
endmodule

// File: tb/tb_render_compositor.sv
// Directed + random check of render_compositor against a pixel-record reference model.
module tb_render_compositor;
   localparam int N  = 10;
   localparam int CW = 12;
   localparam int BD = 2;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hit_valid = 1'b0;
   logic [N-1:0]  hit = '0;
   logic          frame_start = 1'b0;
   logic          pal_we = 1'b0;
   logic [IW-1:0] pal_addr = '0;
   logic [CW-1:0] pal_wdata = '0;
   logic [N-1:0]  blink_mask = '0;
   logic          out_valid;
   logic [CW-1:0] vga_data;

   int total = 0;
   int bad   = 0;

   // reference state: palette, frame count, and the pixel captured last cycle
   logic [CW-1:0] pal [0:N];
   int            fs_cnt;
   logic          rec_v;
   int            rec_i;
   logic          rec_b;
   logic          m_v;
   logic [CW-1:0] m_d;

   render_compositor #(.N_CH(N), .COLOR_W(CW), .BLINK_DIV(BD), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit(hit),
      .frame_start(frame_start), .pal_we(pal_we), .pal_addr(pal_addr),
      .pal_wdata(pal_wdata), .blink_mask(blink_mask),
      .out_valid(out_valid), .vga_data(vga_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int msb(input logic [N-1:0] h);
      int r = N;
      for (int i = 0; i < N; i++) if (h[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) pal[i] = 12'hF00;
      pal[N] = 12'h49C;
      fs_cnt = 0;
      rec_v  = 1'b0;
      rec_i  = N;
      rec_b  = 1'b0;
   endtask

   // predicts outputs after the coming edge from the current inputs
   task automatic model_step();
      m_v = rec_v;
      m_d = rec_v ? (rec_b ? pal[N] : pal[rec_i]) : 12'h000;
      if (pal_we && int'(pal_addr) <= N) pal[pal_addr] = pal_wdata;
      rec_v = hit_valid;
      rec_i = msb(hit);
      rec_b = (rec_i < N) && blink_mask[rec_i] && (((fs_cnt / BD) % 2) == 1);
      if (frame_start) fs_cnt++;
   endtask

   task automatic step(input logic hv, input logic [N-1:0] h, input logic fs,
                       input logic we, input logic [IW-1:0] a, input logic [CW-1:0] wd);
      hit_valid = hv; hit = h; frame_start = fs;
      pal_we = we; pal_addr = a; pal_wdata = wd;
      model_step();
      @(posedge clk); #1;
      chk("model_valid", {11'd0, out_valid}, {11'd0, m_v});
      chk("model_data", vga_data, m_d);
   endtask

   task automatic px(input logic [N-1:0] h, input logic [CW-1:0] exp, input string name);
      step(1'b1, h, 1'b0, 1'b0, '0, '0);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk(name, vga_data, exp);
      chk({name, "_valid"}, {11'd0, out_valid}, 12'd1);
   endtask

   task automatic frame();
      step(1'b0, '0, 1'b1, 1'b0, '0, '0);
   endtask

   initial begin
      model_reset();
      #2;
      chk("reset_valid", {11'd0, out_valid}, 12'd0);
      chk("reset_data", vga_data, 12'h000);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // priority: bit 5 beats bit 0
      px(10'b0000100001, 12'hF00, "prio_default");
      step(1'b0, '0, 1'b0, 1'b1, 4'd5, 12'h123);
      px(10'b0000100001, 12'h123, "prio_pal5");
      px(10'b0000000001, 12'hF00, "prio_ch0");

      // background and blanking
      px('0, 12'h49C, "background");
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("blank_data", vga_data, 12'h000);
      chk("blank_valid", {11'd0, out_valid}, 12'd0);

      // write collides with the stage-2 read of entry 3
      step(1'b1, 10'b0000001000, 1'b0, 1'b0, '0, '0);
      step(1'b1, 10'b0000001000, 1'b0, 1'b1, 4'd3, 12'h0F0);
      chk("collide_old", vga_data, 12'hF00);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("collide_new", vga_data, 12'h0F0);

      // out-of-range write is dropped
      step(1'b0, '0, 1'b0, 1'b1, 4'd11, 12'hABC);
      px('0, 12'h49C, "oor_bg");
      px(10'b1000000000, 12'hF00, "oor_ch9");

      // blink with BLINK_DIV=2: frames 0-1 visible, 2-3 background, 4 visible
      blink_mask = 10'b0010000000;
      px(10'b0010000000, 12'hF00, "blink_f0");
      frame();
      px(10'b0010000000, 12'hF00, "blink_f1");
      step(1'b1, 10'b0010000000, 1'b1, 1'b0, '0, '0);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("blink_same_cycle", vga_data, 12'hF00);
      px(10'b0010000000, 12'h49C, "blink_f2");
      px(10'b0001000000, 12'hF00, "blink_unmasked_f2");
      frame();
      px(10'b0010000000, 12'h49C, "blink_f3");
      frame();
      px(10'b0010000000, 12'hF00, "blink_f4");
      px(10'b0001000000, 12'hF00, "blink_unmasked_f4");
      blink_mask = '0;

      // async reset during a streaming burst
      for (int i = 0; i < 4; i++) step(1'b1, 10'b0000001000, 1'b0, 1'b0, '0, '0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {11'd0, out_valid}, 12'd0);
      chk("async_rst_data", vga_data, 12'h000);
      hit_valid = 1'b0; hit = '0; frame_start = 1'b0; pal_we = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      step(1'b1, 10'b0000001000, 1'b0, 1'b0, '0, '0);
      chk("post_rst_lat1", {11'd0, out_valid}, 12'd0);
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("post_rst_lat2", {11'd0, out_valid}, 12'd1);
      chk("post_rst_pal3", vga_data, 12'hF00);

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         if ((i % 257) == 0) blink_mask = N'($urandom);
         step(($urandom % 4) != 0, N'($urandom) & N'($urandom),
              ($urandom % 40) == 0, ($urandom % 8) == 0,
              IW'($urandom % 16), CW'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
